// File: rtl/usr_serial_pkg.sv
// Shared definitions for the usr serial link (receiver and transmitter).
// State encoding, idle line level and even-parity helper.
package usr_serial_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } serial_state_e;

    localparam logic LineIdle = 1'b1;

    localparam int unsigned MaxDataW = 64;

    // Even parity bit: XOR of data bits and this bit is zero.
    function automatic logic even_parity_bit(input logic [MaxDataW-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/usr_rx_shreg.sv
// Serial-in, parallel-out right-shift register: new bits enter at the MSB.
// Asynchronous active-low clear.
module usr_rx_shreg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] q_q;
    logic [Width-1:0] q_d;

    if (Width == 1) begin : g_single
        assign q_d = en_i ? d_i : q_q;
    end else begin : g_multi
        assign q_d = en_i ? {d_i, q_q[Width-1:1]} : q_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/usr_serial_rx.sv
// Start/data/stop frame receiver with valid/ready output and error pulses.
// Define USR_RX_PARITY_EN to add an even-parity bit between data and stop.
module usr_serial_rx
    import usr_serial_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sin,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitW = $clog2(DATA_W + 1);

    serial_state_e     state_q, state_d;
    logic [CntW-1:0]   cyc_q, cyc_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic              done_q, done_d;
    logic              stop_q, stop_d;
    logic              par_bad_q, par_bad_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              perr_q, perr_d;
    logic              ovr_q, ovr_d;
    logic              shift_en;
    logic [DATA_W-1:0] shreg_q;
    logic              bit_tick;
    logic              half_tick;
    logic              xfer;
    logic              good;

    usr_rx_shreg #(
        .Width (DATA_W)
    ) u_shreg (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (shift_en),
        .d_i    (sin),
        .q_o    (shreg_q)
    );

    assign bit_tick  = (cyc_q == CntW'(CLKS_PER_BIT - 1));
    assign half_tick = (cyc_q == CntW'(CLKS_PER_BIT / 2 - 1));

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        bit_d     = bit_q;
        done_d    = 1'b0;
        stop_d    = stop_q;
        par_bad_d = par_bad_q;
        shift_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sin != LineIdle) begin
                    state_d   = StStart;
                    cyc_d     = '0;
                    bit_d     = '0;
                    par_bad_d = 1'b0;
                end
            end
            StStart: begin
                if (half_tick) begin
                    cyc_d   = '0;
                    state_d = (sin == LineIdle) ? StIdle : StData;
                end else begin
                    cyc_d = cyc_q + CntW'(1);
                end
            end
            StData: begin
                if (bit_tick) begin
                    cyc_d    = '0;
                    shift_en = 1'b1;
                    bit_d    = bit_q + BitW'(1);
                    if (bit_q == BitW'(DATA_W - 1)) begin
`ifdef USR_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end else begin
                    cyc_d = cyc_q + CntW'(1);
                end
            end
`ifdef USR_RX_PARITY_EN
            StParity: begin
                if (bit_tick) begin
                    cyc_d     = '0;
                    par_bad_d = even_parity_bit(MaxDataW'(shreg_q)) ^ sin;
                    state_d   = StStop;
                end else begin
                    cyc_d = cyc_q + CntW'(1);
                end
            end
`endif
            StStop: begin
                if (bit_tick) begin
                    cyc_d   = '0;
                    done_d  = 1'b1;
                    stop_d  = sin;
                    state_d = StIdle;
                end else begin
                    cyc_d = cyc_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Frame verdict is applied one edge after the stop sample, so all outputs stay registered.
    always_comb begin
        xfer    = valid_q && dout_ready;
        good    = done_q && stop_q && !par_bad_q;
        dout_d  = dout_q;
        valid_d = valid_q && !xfer;
        ovr_d   = 1'b0;
        ferr_d  = done_q && !stop_q;
        perr_d  = done_q && par_bad_q;
        if (good) begin
            if (!valid_q || xfer) begin
                dout_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cyc_q     <= '0;
            bit_q     <= '0;
            done_q    <= 1'b0;
            stop_q    <= 1'b0;
            par_bad_q <= 1'b0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            bit_q     <= bit_d;
            done_q    <= done_d;
            stop_q    <= stop_d;
            par_bad_q <= par_bad_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_usr_serial_rx.sv
// Scoreboard bench for usr_serial_rx: stimulus pushes expected events, a monitor pops them.
// Parity scenarios run only when USR_RX_PARITY_EN is defined.
module tb_usr_serial_rx;

    localparam int DATA_W = 8;
    localparam int CPB    = 4;
    localparam int H      = CPB / 2;
`ifdef USR_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    typedef enum int {EvNone, EvData, EvFerr, EvPerr, EvOvr} ev_e;
    typedef struct {
        ev_e        kind;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sin = 1'b1;
    logic       dout_ready = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    int  edge_n = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t sb_q[$];

    usr_serial_rx #(
        .DATA_W       (DATA_W),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sin        (sin),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_check(input ev_e kind, input logic [7:0] data);
        ev_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d data %0h at edge %0d expected none",
                     kind, data, edge_n);
        end else begin
            e = sb_q.pop_front();
            if (e.kind != kind || e.data !== data || (e.cyc >= 0 && e.cyc != edge_n)) begin
                errors++;
                $display("FAIL event: got kind %0d data %0h edge %0d expected kind %0d data %0h edge %0d",
                         kind, data, edge_n, e.kind, e.data, e.cyc);
            end
        end
    endtask

    // Monitor: every transfer or pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (dout_valid && dout_ready) pop_check(EvData, dout);
            if (frame_err)  pop_check(EvFerr, 8'h00);
            if (parity_err) pop_check(EvPerr, 8'h00);
            if (overrun)    pop_check(EvOvr, 8'h00);
        end
    end

    // Drives one frame starting at the next edge (cycle 0); abort_at >= 0 pulses reset there.
    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                              input ev_e exp_kind, input int abort_at);
        logic [15:0] bits;
        int          nbits;
        int          t0;
        ev_t         e;
        nbits = DATA_W + 2 + P;
        t0    = edge_n + 1;
        bits  = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < DATA_W; i++) bits[1 + i] = data[i];
        if (P == 1) bits[DATA_W + 1] = par;
        bits[nbits - 1] = stop;
        if (exp_kind != EvNone) begin
            e.kind = exp_kind;
            e.data = (exp_kind == EvData) ? data : 8'h00;
            e.cyc  = t0 + H + (DATA_W + 1 + P) * CPB + 1;
            sb_q.push_back(e);
        end
        for (int c = 0; c < nbits * CPB; c++) begin
            if (c == abort_at) begin
                reset = 1'b0;
                sin   = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("reset_mid_frame_outs",
                        {dout, dout_valid, frame_err, parity_err, overrun}, 32'h0);
                    @(posedge clk);
                    #1;
                end
                reset = 1'b1;
                return;
            end
            sin = bits[c / CPB];
            @(posedge clk);
            #1;
        end
        sin = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #(200000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_cycles(3);
        @(negedge clk);
        chk("reset_outs", {dout, dout_valid, frame_err, parity_err, overrun}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_cycles(3);

        // Plain good frame, consumer always ready.
        dout_ready = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b1, EvData, -1);
        idle_cycles(4);

        // False start: one low cycle, then a real frame.
        sin = 1'b0;
        idle_cycles(1);
        sin = 1'b1;
        idle_cycles(8);
        send_frame(8'hF0, 1'b0, 1'b1, EvData, -1);
        idle_cycles(4);
        chk("false_start_dout", {24'h0, dout}, 32'hF0);

        // Stop bit low: frame error, output untouched.
        send_frame(8'h55, 1'b0, 1'b0, EvFerr, -1);
        idle_cycles(4);
        chk("ferr_dout_kept", {23'h0, dout_valid, dout}, {23'h0, 1'b0, 8'hF0});

        // Consumer stalled: second frame overruns, first is kept.
        dout_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, EvNone, -1);
        send_frame(8'h22, 1'b0, 1'b1, EvOvr, -1);
        idle_cycles(4);
        chk("overrun_held", {23'h0, dout_valid, dout}, {23'h0, 1'b1, 8'h11});
        begin
            ev_t e;
            e.kind = EvData;
            e.data = 8'h11;
            e.cyc  = -1;
            sb_q.push_back(e);
        end
        dout_ready = 1'b1;
        idle_cycles(1);
        @(negedge clk);
        chk("valid_clears", {31'h0, dout_valid}, 32'h0);
        idle_cycles(2);

`ifdef USR_RX_PARITY_EN
        send_frame(8'h3C, 1'b0, 1'b1, EvData, -1);
        idle_cycles(4);
        send_frame(8'h3C, 1'b1, 1'b1, EvPerr, -1);
        idle_cycles(4);
        chk("perr_no_valid", {31'h0, dout_valid}, 32'h0);
`endif

        // Reset mid-frame, idle line afterwards, then a clean frame.
        send_frame(8'h81, 1'b0, 1'b1, EvNone, 20);
        idle_cycles(60);
        @(negedge clk);
        chk("post_reset_quiet", {dout, dout_valid, frame_err, parity_err, overrun}, 32'h0);
        idle_cycles(1);
        send_frame(8'h81, 1'b0, 1'b1, EvData, -1);
        idle_cycles(6);

        chk("scoreboard_drained", sb_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
